// File: rtl/key_search_ctrl.sv
// Sequencer for a brute-force key search: runs the S-init, shuffle and decrypt loops for each key
// and walks the key range until the checker reports a match, the range is exhausted, or a loop hangs.
module key_search_ctrl #(
    parameter logic [23:0] KEY_MIN = 24'h000000,
    parameter logic [23:0] KEY_MAX = 24'h3FFFFF,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        loop1_start,
    output logic        loop2_start,
    output logic        loop3_start,
    input  logic        loop1_done,
    input  logic        loop2_done,
    input  logic        loop3_done,
    input  logic        start_over,
    input  logic        found_key,
    output logic        loops_clear,
    output logic [23:0] key,
    output logic [23:0] keys_tried,
    output logic        busy,
    output logic        found,
    output logic        not_found,
    output logic        error,
    output logic [1:0]  leds
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_RUN1  = 4'd1;
    localparam logic [3:0] S_WAIT1 = 4'd2;
    localparam logic [3:0] S_RUN2  = 4'd3;
    localparam logic [3:0] S_WAIT2 = 4'd4;
    localparam logic [3:0] S_RUN3  = 4'd5;
    localparam logic [3:0] S_WAIT3 = 4'd6;
    localparam logic [3:0] S_NEXT  = 4'd7;
    localparam logic [3:0] S_FOUND = 4'd8;
    localparam logic [3:0] S_FAIL  = 4'd9;
    localparam logic [3:0] S_ERR   = 4'd10;

    logic [3:0]      state_q, state_d;
    logic [23:0]     key_q, key_d;
    logic [23:0]     tried_q, tried_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            clear_q, clear_d;
    logic            l1_q, l2_q, l3_q;
    logic            busy_q, found_q, nf_q, err_q;
    logic [1:0]      leds_q;
    logic            wd_expired;

    function automatic logic [1:0] leds_for(input logic [3:0] s);
        case (s)
            S_FOUND: leds_for = 2'b01;
            S_FAIL:  leds_for = 2'b10;
            S_ERR:   leds_for = 2'b11;
            default: leds_for = 2'b00;
        endcase
    endfunction

    function automatic logic busy_for(input logic [3:0] s);
        busy_for = (s inside {S_RUN1, S_WAIT1, S_RUN2, S_WAIT2, S_RUN3, S_WAIT3, S_NEXT});
    endfunction

    assign wd_expired = (wd_q == WD_LAST);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        tried_d = tried_q;
        wd_d    = wd_q;
        clear_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN1;
                    key_d   = KEY_MIN;
                    tried_d = '0;
                end
            end
            S_RUN1: begin
                wd_d    = '0;
                state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (loop1_done) begin
                    state_d = S_RUN2;
                end else if (wd_expired) begin
                    state_d = S_ERR;
                    clear_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RUN2: begin
                wd_d    = '0;
                state_d = S_WAIT2;
            end
            S_WAIT2: begin
                if (loop2_done) begin
                    state_d = S_RUN3;
                end else if (wd_expired) begin
                    state_d = S_ERR;
                    clear_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RUN3: begin
                wd_d    = '0;
                state_d = S_WAIT3;
            end
            S_WAIT3: begin
                // A match outranks a simultaneous reject; decrypt finishing with no reject is a match too.
                if (found_key) begin
                    state_d = S_FOUND;
                end else if (start_over) begin
                    state_d = S_NEXT;
                    clear_d = 1'b1;
                    tried_d = tried_q + 24'd1;
                end else if (loop3_done) begin
                    state_d = S_FOUND;
                end else if (wd_expired) begin
                    state_d = S_ERR;
                    clear_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_NEXT: begin
                if (key_q == KEY_MAX) begin
                    state_d = S_FAIL;
                end else begin
                    key_d   = key_q + 24'd1;
                    state_d = S_RUN1;
                end
            end
            S_FOUND, S_FAIL, S_ERR: begin
                if (start) begin
                    state_d = S_RUN1;
                    key_d   = KEY_MIN;
                    tried_d = '0;
                    clear_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every output is derived from the next state so it is valid in the cycle that state is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            key_q   <= KEY_MIN;
            tried_q <= '0;
            wd_q    <= '0;
            clear_q <= 1'b0;
            l1_q    <= 1'b0;
            l2_q    <= 1'b0;
            l3_q    <= 1'b0;
            busy_q  <= 1'b0;
            found_q <= 1'b0;
            nf_q    <= 1'b0;
            err_q   <= 1'b0;
            leds_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            tried_q <= tried_d;
            wd_q    <= wd_d;
            clear_q <= clear_d;
            l1_q    <= (state_d == S_RUN1);
            l2_q    <= (state_d == S_RUN2);
            l3_q    <= (state_d == S_RUN3);
            busy_q  <= busy_for(state_d);
            found_q <= (state_d == S_FOUND);
            nf_q    <= (state_d == S_FAIL);
            err_q   <= (state_d == S_ERR);
            leds_q  <= leds_for(state_d);
        end
    end

    assign loop1_start = l1_q;
    assign loop2_start = l2_q;
    assign loop3_start = l3_q;
    assign loops_clear = clear_q;
    assign key         = key_q;
    assign keys_tried  = tried_q;
    assign busy        = busy_q;
    assign found       = found_q;
    assign not_found   = nf_q;
    assign error       = err_q;
    assign leds        = leds_q;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench for key_search_ctrl: loop-start/clear pulses are scoreboarded against a queue of
// expected events; status and key values are checked at each step.
module tb_key_search_ctrl;

    localparam logic [23:0] KMIN = 24'd0;
    localparam logic [23:0] KMAX = 24'd3;
    localparam int          TO   = 16;

    logic        clk = 1'b0;
    logic        reset, start;
    logic        loop1_done, loop2_done, loop3_done, start_over, found_key;
    logic        loop1_start, loop2_start, loop3_start, loops_clear;
    logic [23:0] key, keys_tried;
    logic        busy, found, not_found, error;
    logic [1:0]  leds;

    int n_cmp = 0;
    int n_err = 0;
    int n_l1  = 0;
    int n_clr = 0;
    int s_l1, s_clr;

    // Event code: {loops_clear, loop3_start, loop2_start, loop1_start}
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_ev, mon_want;
    logic [23:0] exp_key, exp_tried;

    key_search_ctrl #(.KEY_MIN(KMIN), .KEY_MAX(KMAX), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .loop1_start(loop1_start), .loop2_start(loop2_start), .loop3_start(loop3_start),
        .loop1_done(loop1_done), .loop2_done(loop2_done), .loop3_done(loop3_done),
        .start_over(start_over), .found_key(found_key), .loops_clear(loops_clear),
        .key(key), .keys_tried(keys_tried), .busy(busy), .found(found),
        .not_found(not_found), .error(error), .leds(leds)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        mon_ev = {loops_clear, loop3_start, loop2_start, loop1_start};
        if (|mon_ev === 1'b1) begin
            if (loop1_start === 1'b1) n_l1++;
            if (loops_clear === 1'b1) n_clr++;
            mon_want = 4'b0000;
            if (exp_q.size() > 0) mon_want = exp_q.pop_front();
            n_cmp++;
            assert (mon_ev === mon_want) else begin
                n_err++;
                $error("FAIL pulse_event: observed=%b required=%b", mon_ev, mon_want);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running required=finished");
        $fatal(1, "bench time limit reached");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed=%0h required=%0h", tag, obs, want);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed=%b required=%b", tag, obs, want);
        end
    endtask

    function automatic logic lsig(input int which);
        case (which)
            1:       lsig = loop1_start;
            2:       lsig = loop2_start;
            default: lsig = loop3_start;
        endcase
    endfunction

    task automatic wait_l(input int which);
        int   n;
        logic s;
        n = 0;
        s = lsig(which);
        while (s !== 1'b1 && n < 40) begin
            cycle();
            n++;
            s = lsig(which);
        end
        chk1($sformatf("loop%0d_start_seen", which), s, 1'b1);
    endtask

    task automatic clear_inputs();
        start = 0; loop1_done = 0; loop2_done = 0; loop3_done = 0;
        start_over = 0; found_key = 0;
    endtask

    task automatic restart(input bit from_idle);
        start = 1;
        exp_q.push_back(from_idle ? 4'b0001 : 4'b1001);
        cycle();
        start = 0;
        exp_key   = KMIN;
        exp_tried = 24'd0;
        chk1("busy_on_restart", busy, 1'b1);
        chk1("found_on_restart", found, 1'b0);
        chk24("tried_on_restart", keys_tried, 24'd0);
    endtask

    // act: 0 found_key, 1 start_over, 2 loop3_done alone, 3 found_key+start_over, 4 stop in WAIT3
    task automatic run_key(input int act, input bit spur);
        wait_l(1);
        chk24("key_at_run1", key, exp_key);
        chk1("busy_in_run1", busy, 1'b1);
        if (spur) begin
            cycle();
            loop3_done = 1; loop2_done = 1; start_over = 1; found_key = 1; start = 1;
            cycle();
            clear_inputs();
            chk1("busy_after_spurious", busy, 1'b1);
            chk1("found_after_spurious", found, 1'b0);
            cycle();
        end else begin
            repeat (3) cycle();
        end
        loop1_done = 1;
        exp_q.push_back(4'b0010);
        cycle();
        loop1_done = 0;
        wait_l(2);
        repeat (3) cycle();
        loop2_done = 1;
        exp_q.push_back(4'b0100);
        cycle();
        loop2_done = 0;
        wait_l(3);
        repeat (3) cycle();
        if (act != 4) begin
            case (act)
                0: found_key = 1;
                1: begin
                    start_over = 1;
                    exp_q.push_back(4'b1000);
                    if (exp_key != KMAX) exp_q.push_back(4'b0001);
                end
                2: loop3_done = 1;
                default: begin found_key = 1; start_over = 1; end
            endcase
            cycle();
            clear_inputs();
            if (act == 1) begin
                exp_tried = exp_tried + 24'd1;
                chk24("tried_in_next", keys_tried, exp_tried);
                chk1("busy_in_next", busy, 1'b1);
                if (exp_key != KMAX) exp_key = exp_key + 24'd1;
            end
        end
    endtask

    task automatic chk_end(input string tag, input logic f, input logic nf, input logic e,
                           input logic [1:0] l, input logic [23:0] k, input logic [23:0] t);
        chk1({tag, "_found"}, found, f);
        chk1({tag, "_not_found"}, not_found, nf);
        chk1({tag, "_error"}, error, e);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk24({tag, "_leds"}, 24'(leds), 24'(l));
        chk24({tag, "_key"}, key, k);
        chk24({tag, "_tried"}, keys_tried, t);
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        repeat (3) cycle();
        reset = 0;
        cycle();
        chk_end("reset", 1'b0, 1'b0, 1'b0, 2'b00, 24'd0, 24'd0);
        chk24("reset_pulses", 24'({loops_clear, loop3_start, loop2_start, loop1_start}), 24'd0);

        // Match on the first key
        restart(1'b1);
        run_key(0, 1'b0);
        chk_end("s1", 1'b1, 1'b0, 1'b0, 2'b01, 24'd0, 24'd0);

        // Reject keys 0 and 1, match key 2; clears = restart clear + one per rejected key
        s_l1 = n_l1; s_clr = n_clr;
        restart(1'b0);
        run_key(1, 1'b0);
        run_key(1, 1'b0);
        run_key(0, 1'b0);
        chk_end("s2", 1'b1, 1'b0, 1'b0, 2'b01, 24'd2, 24'd2);
        chk24("s2_loop1_pulses", 24'(n_l1 - s_l1), 24'd3);
        chk24("s2_clear_pulses", 24'(n_clr - s_clr), 24'd3);

        // Reject every key: range exhausted
        restart(1'b0);
        for (int i = 0; i < 4; i++) run_key(1, 1'b0);
        cycle();
        chk_end("s3", 1'b0, 1'b1, 1'b0, 2'b10, 24'd3, 24'd4);

        // loop2_done withheld: watchdog fires 16 cycles after WAIT2 entry
        restart(1'b0);
        wait_l(1);
        repeat (3) cycle();
        loop1_done = 1;
        exp_q.push_back(4'b0010);
        cycle();
        loop1_done = 0;
        wait_l(2);
        exp_q.push_back(4'b1000);
        repeat (16) cycle();
        chk1("s4_error_early", error, 1'b0);
        chk1("s4_busy_early", busy, 1'b1);
        cycle();
        chk1("s4_loops_clear", loops_clear, 1'b1);
        chk_end("s4", 1'b0, 1'b0, 1'b1, 2'b11, 24'd0, 24'd0);

        // Spurious pulses in WAIT1, then simultaneous found_key and start_over
        restart(1'b0);
        run_key(3, 1'b1);
        chk_end("s5", 1'b1, 1'b0, 1'b0, 2'b01, 24'd0, 24'd0);

        // Decrypt completes with no reject
        restart(1'b0);
        run_key(2, 1'b0);
        chk_end("s5b", 1'b1, 1'b0, 1'b0, 2'b01, 24'd0, 24'd0);

        // Reset mid-search in WAIT3 on key 2, with every other input asserted
        restart(1'b0);
        run_key(1, 1'b0);
        run_key(1, 1'b0);
        run_key(4, 1'b0);
        chk24("s6_key_before_reset", key, 24'd2);
        chk1("s6_busy_before_reset", busy, 1'b1);
        reset = 1; start = 1; start_over = 1; found_key = 1; loop3_done = 1;
        cycle();
        reset = 0;
        clear_inputs();
        chk_end("s6_reset", 1'b0, 1'b0, 1'b0, 2'b00, 24'd0, 24'd0);
        chk1("s6_clear_after_reset", loops_clear, 1'b0);
        cycle();
        chk1("s6_idle_busy", busy, 1'b0);
        chk1("s6_idle_loop1", loop1_start, 1'b0);
        restart(1'b1);
        run_key(0, 1'b0);
        chk_end("s6_rerun", 1'b1, 1'b0, 1'b0, 2'b01, 24'd0, 24'd0);

        repeat (2) cycle();
        chk24("scoreboard_drained", 24'(exp_q.size()), 24'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_search_ctrl.md
KEY_SEARCH_CTRL -- requirements
Module: key_search_ctrl

Interface
Parameters:
REQ-001 SHALL have parameter KEY_MIN, default 24'h000000, first key tried.
REQ-002 SHALL have parameter KEY_MAX, default 24'h3FFFFF, last key tried.
REQ-003 SHALL have parameter TIMEOUT, default 65535, max cycles any loop may take before done.

Ports:
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse; begins a search.
REQ-007 SHALL have ports loop1_start, loop2_start, loop3_start  out  1 each  one-cycle start pulses to S-init, shuffle and decrypt loops.
REQ-008 SHALL have ports loop1_done, loop2_done, loop3_done  in  1 each  one-cycle completion pulses from those loops.
REQ-009 SHALL have port start_over  in  1  checker pulse: current key produced an invalid character.
REQ-010 SHALL have port found_key  in  1  checker pulse: current key fully matched.
REQ-011 SHALL have port loops_clear  out  1  one-cycle pulse forcing all loops back to init.
REQ-012 SHALL have port key  out  24  key currently under test.
REQ-013 SHALL have port keys_tried  out  24  count of keys rejected in this search.
REQ-014 SHALL have ports busy, found, not_found, error  out  1 each  status.
REQ-015 SHALL have port leds  out  2  00 idle/busy, 01 found, 10 not_found, 11 error.

Function
REQ-016 SHALL implement states IDLE, RUN1, WAIT1, RUN2, WAIT2, RUN3, WAIT3, NEXT, FOUND, FAIL, ERR.
REQ-017 IDLE: on start, SHALL load key=KEY_MIN, keys_tried=0, and go to RUN1.
REQ-018 RUNn SHALL assert loopn_start for exactly one cycle, clear the watchdog, and go to WAITn next cycle.
REQ-019 WAIT1/WAIT2: loopn_done SHALL advance to RUN2/RUN3 respectively.
REQ-020 WAIT3 priority SHALL be found_key > start_over > loop3_done.
REQ-021 In WAIT3, found_key SHALL go to FOUND; loop3_done alone (all characters passed) SHALL also go to FOUND.
REQ-022 In WAIT3, start_over without found_key SHALL go to NEXT.
REQ-023 NEXT SHALL pulse loops_clear for one cycle and increment keys_tried.
REQ-024 NEXT with key==KEY_MAX SHALL go to FAIL, key held at KEY_MAX; otherwise key SHALL increment by 1 and go to RUN1.
REQ-025 Key increment SHALL never wrap past KEY_MAX.
REQ-026 Done, found_key and start_over pulses arriving in states not waiting for them SHALL be ignored.
REQ-027 The watchdog SHALL count cycles in each WAITn; reaching TIMEOUT without the awaited pulse SHALL go to ERR and pulse loops_clear.
REQ-028 FOUND, FAIL and ERR SHALL be sticky, with key frozen at its last value.
REQ-029 start in FOUND, FAIL or ERR SHALL pulse loops_clear and restart exactly as from IDLE.
REQ-030 start while busy SHALL be ignored.
REQ-031 busy SHALL be 1 in RUNn, WAITn and NEXT, else 0.
REQ-032 found, not_found and error SHALL be 1 only in FOUND, FAIL and ERR respectively.
REQ-033 All outputs SHALL be registered, with status updating on the cycle the state is entered.

Reset
REQ-034 reset SHALL force IDLE from any state, including mid-search.
REQ-035 Reset values SHALL be: key=KEY_MIN, keys_tried=0, watchdog=0, all start pulses, loops_clear, busy, found, not_found and error =0, leds=00.
REQ-036 reset SHALL take priority over start and over all handshake inputs in the same cycle.

Verification (KEY_MIN=0, KEY_MAX=3, TIMEOUT=16)
REQ-037 Bench SHALL cover: start; loops done after 3 cycles each; found_key on key 0 -> found=1, leds=01, key=0, keys_tried=0.
REQ-038 Bench SHALL cover: start_over on keys 0 and 1, found_key on key 2 -> three loop1_start pulses, two loops_clear pulses, key=2, keys_tried=2, found=1.
REQ-039 Bench SHALL cover: start_over on every key -> after key 3 rejected, not_found=1, leds=10, key=3, keys_tried=4.
REQ-040 Bench SHALL cover: loop2_done withheld -> error=1 and leds=11 exactly 16 cycles after WAIT2 entry, with a loops_clear pulse.
REQ-041 Bench SHALL cover: start_over and found_key in the same cycle -> FOUND; a spurious loop3_done during WAIT1 -> ignored.
REQ-042 Bench SHALL cover: reset asserted during WAIT3 with key=2 -> next cycle IDLE, key=0, busy=0; a following start restarts from key 0.
